// File: rtl/axi4_sub_pkg.sv
// axi4_sub_pkg: shared states, response/burst codes and request helpers for axi4_sub_mem
package axi4_sub_pkg;
  // Request fields are held at a fixed maximum width and sized at the ports.
  localparam int REQ_ID_W = 32;
  localparam int REQ_ADDR_W = 64;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;
  typedef struct packed {
    logic [REQ_ID_W-1:0] id;
    logic [REQ_ADDR_W-1:0] addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } req_t;
  function automatic logic [REQ_ADDR_W-1:0] next_addr(req_t r);
    return (r.burst == BURST_INCR) ? r.addr + (REQ_ADDR_W'(1) << r.size) : r.addr;
  endfunction
  function automatic logic beat_err(req_t r, int unsigned offs, int unsigned depth);
    return (r.burst != BURST_FIXED && r.burst != BURST_INCR) || (32'(r.size) > offs) ||
           ((r.addr >> offs) >= REQ_ADDR_W'(depth));
  endfunction
endpackage

// File: rtl/axi4_bus_if.sv
// axi4_bus_if: full AXI4 AW/W/B/AR/R bundle with a subordinate-side modport
interface axi4_bus_if #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 9,
  parameter int AXI_USER_WIDTH = 5
);
  logic [AXI_ID_WIDTH-1:0] aw_id, b_id, ar_id, r_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr, ar_addr;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic aw_lock, ar_lock;
  logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic [AXI_USER_WIDTH-1:0] aw_user, w_user, b_user, ar_user, r_user;
  logic aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [AXI_DATA_WIDTH-1:0] w_data, r_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  modport sub (
    input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
          aw_region, aw_user, aw_valid,
    output aw_ready,
    input w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input b_ready,
    input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
          ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input r_ready
  );
endinterface

// File: rtl/axi4_sub_ram.sv
// axi4_sub_ram: byte-enabled write port plus registered read port, BRAM-inferable
module axi4_sub_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i)
      for (int i = 0; i < DATA_W/8; i++)
        if (be_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi4_sub_mem.sv
// axi4_sub_mem: AXI4 subordinate memory with independent write and read FSMs over a BRAM
module axi4_sub_mem
  import axi4_sub_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH = 9,
  parameter int AXI_USER_WIDTH = 5,
  parameter int MEM_DEPTH = 1024
) (
  input  logic    clk_i,
  input  logic    rstn_i,
  axi4_bus_if.sub axi_sub_if,
  output logic    wr_busy_o,
  output logic    rd_busy_o
);
  localparam int OFFS = $clog2(AXI_DATA_WIDTH/8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  logic rdy_en_q;
  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  req_t aw_q, aw_d, ar_q, ar_d;
  logic [7:0] w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;
  logic w_err_q, w_err_d, r_err_q, r_err_d;
  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, we, re, w_bad, r_bad, w_end, r_end;
  logic [AXI_DATA_WIDTH-1:0] rdata;
  assign w_bad = beat_err(aw_q, OFFS, MEM_DEPTH);
  assign r_bad = beat_err(ar_q, OFFS, MEM_DEPTH);
  assign w_end = w_cnt_q == aw_q.len;
  assign r_end = r_cnt_q == ar_q.len;
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdy_en_q <= 1'b0;
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_q <= '0;
      ar_q <= '0;
      w_cnt_q <= '0;
      r_cnt_q <= '0;
      w_err_q <= 1'b0;
      r_err_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_q <= aw_d;
      ar_q <= ar_d;
      w_cnt_q <= w_cnt_d;
      r_cnt_q <= r_cnt_d;
      w_err_q <= w_err_d;
      r_err_q <= r_err_d;
    end
  end
  always_comb begin
    w_state_d = w_state_q;
    aw_d = aw_q;
    w_cnt_d = w_cnt_q;
    w_err_d = w_err_q;
    aw_rdy = 1'b0;
    w_rdy = 1'b0;
    b_vld = 1'b0;
    we = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_rdy = rdy_en_q;
        if (rdy_en_q && axi_sub_if.aw_valid) begin
          aw_d.id = {{(REQ_ID_W-AXI_ID_WIDTH){1'b0}}, axi_sub_if.aw_id};
          aw_d.addr = {{(REQ_ADDR_W-AXI_ADDR_WIDTH){1'b0}}, axi_sub_if.aw_addr};
          aw_d.len = axi_sub_if.aw_len;
          aw_d.size = axi_sub_if.aw_size;
          aw_d.burst = axi_sub_if.aw_burst;
          w_cnt_d = '0;
          w_err_d = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_rdy = 1'b1;
        if (axi_sub_if.w_valid) begin
          we = !w_bad;
          // A misplaced w_last is only reported; the beat counter still ends the burst.
          w_err_d = w_err_q | w_bad | (axi_sub_if.w_last != w_end);
          w_cnt_d = w_cnt_q + 8'd1;
          aw_d.addr = next_addr(aw_q);
          w_state_d = w_end ? W_RESP : W_DATA;
        end
      end
      W_RESP: begin
        b_vld = 1'b1;
        if (axi_sub_if.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  always_comb begin
    r_state_d = r_state_q;
    ar_d = ar_q;
    r_cnt_d = r_cnt_q;
    r_err_d = r_err_q;
    ar_rdy = 1'b0;
    r_vld = 1'b0;
    re = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_rdy = rdy_en_q;
        if (rdy_en_q && axi_sub_if.ar_valid) begin
          ar_d.id = {{(REQ_ID_W-AXI_ID_WIDTH){1'b0}}, axi_sub_if.ar_id};
          ar_d.addr = {{(REQ_ADDR_W-AXI_ADDR_WIDTH){1'b0}}, axi_sub_if.ar_addr};
          ar_d.len = axi_sub_if.ar_len;
          ar_d.size = axi_sub_if.ar_size;
          ar_d.burst = axi_sub_if.ar_burst;
          r_cnt_d = '0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        re = 1'b1;
        r_err_d = r_bad;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        r_vld = 1'b1;
        if (axi_sub_if.r_ready) begin
          r_cnt_d = r_cnt_q + 8'd1;
          ar_d.addr = next_addr(ar_q);
          r_state_d = r_end ? R_IDLE : R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  axi4_sub_ram #(.DATA_W(AXI_DATA_WIDTH), .DEPTH(MEM_DEPTH)) u_ram (
    .clk_i  (clk_i),
    .we_i   (we),
    .be_i   (axi_sub_if.w_strb),
    .waddr_i(aw_q.addr[OFFS +: IDX_W]),
    .wdata_i(axi_sub_if.w_data),
    .re_i   (re),
    .raddr_i(ar_q.addr[OFFS +: IDX_W]),
    .rdata_o(rdata)
  );
  assign axi_sub_if.aw_ready = aw_rdy;
  assign axi_sub_if.w_ready = w_rdy;
  assign axi_sub_if.b_valid = b_vld;
  assign axi_sub_if.b_id = aw_q.id[AXI_ID_WIDTH-1:0];
  assign axi_sub_if.b_resp = w_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi_sub_if.b_user = {AXI_USER_WIDTH{1'b0}};
  assign axi_sub_if.ar_ready = ar_rdy;
  assign axi_sub_if.r_valid = r_vld;
  assign axi_sub_if.r_id = ar_q.id[AXI_ID_WIDTH-1:0];
  assign axi_sub_if.r_data = r_err_q ? '0 : rdata;
  assign axi_sub_if.r_resp = r_err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi_sub_if.r_last = r_end;
  assign axi_sub_if.r_user = {AXI_USER_WIDTH{1'b0}};
  assign wr_busy_o = w_state_q != W_IDLE;
  assign rd_busy_o = r_state_q != R_IDLE;
endmodule

// File: tb/tb_axi4_sub_mem.sv
// tb_axi4_sub_mem: scoreboard bench with an array memory model for axi4_sub_mem
module tb_axi4_sub_mem;
  typedef struct {logic [8:0] id; logic [1:0] resp;} b_exp_t;
  typedef struct {logic [8:0] id; logic [63:0] data; logic [1:0] resp; logic last;} r_exp_t;
  logic clk = 0, rstn = 0, wr_busy, rd_busy;
  bit rand_rdy = 1;
  int tests = 0, fails = 0;
  b_exp_t bq[$];
  r_exp_t rq[$];
  logic [63:0] mem [1024];
  logic [63:0] wd [256];
  logic [7:0] ws [256];
  always #5 clk = ~clk;
  axi4_bus_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(9), .AXI_USER_WIDTH(5)) bus ();
  axi4_sub_mem #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(9), .AXI_USER_WIDTH(5),
                 .MEM_DEPTH(1024)) dut (
    .clk_i(clk), .rstn_i(rstn), .axi_sub_if(bus), .wr_busy_o(wr_busy), .rd_busy_o(rd_busy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit bad_beat(logic [31:0] a, logic [2:0] size, logic [1:0] burst);
    return !(burst inside {2'b00, 2'b01}) || size > 3'd3 || (a >> 3) >= 32'd1024;
  endfunction

  function automatic logic [31:0] adv(logic [31:0] a, logic [2:0] size, logic [1:0] burst);
    return (burst == 2'b01) ? a + (32'd1 << size) : a;
  endfunction

  always @(posedge clk) begin
    #3;
    if (rand_rdy) begin
      bus.r_ready = 1'($urandom_range(0, 1));
      bus.b_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    b_exp_t be;
    r_exp_t re;
    if (rstn && bus.b_valid && bus.b_ready) begin
      if (bq.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_unexpected: B response id %h appeared with none expected", bus.b_id);
      end else begin
        be = bq.pop_front();
        chk("b_id", 64'(bus.b_id), 64'(be.id));
        chk("b_resp", 64'(bus.b_resp), 64'(be.resp));
        chk("b_user", 64'(bus.b_user), 64'(5'd0));
      end
    end
    if (rstn && bus.r_valid && bus.r_ready) begin
      if (rq.size() == 0) begin
        tests++; fails++;
        $display("FAIL r_unexpected: R beat id %h appeared with none expected", bus.r_id);
      end else begin
        re = rq.pop_front();
        chk("r_id", 64'(bus.r_id), 64'(re.id));
        chk("r_data", bus.r_data, re.data);
        chk("r_resp", 64'(bus.r_resp), 64'(re.resp));
        chk("r_last", 64'(bus.r_last), 64'(re.last));
        chk("r_user", 64'(bus.r_user), 64'(5'd0));
      end
    end
  end

  task automatic wait_hs(input int ch, input string name);
    bit got;
    int n = 0;
    do begin
      @(negedge clk);
      got = (ch == 0) ? bus.aw_ready : (ch == 1) ? bus.w_ready : bus.ar_ready;
      @(posedge clk); #1;
      n++;
    end while (!got && n < 100);
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s: no ready within 100 cycles", name);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL drain: %0d B and %0d R responses still outstanding", bq.size(), rq.size());
      bq.delete(); rq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int flip,
                          input bit wait_b);
    logic [31:0] a = addr;
    bit err = 0;
    for (int i = 0; i <= int'(len); i++) begin
      if (bad_beat(a, size, burst)) err = 1;
      else for (int b = 0; b < 8; b++) if (ws[i][b]) mem[a >> 3][b*8 +: 8] = wd[i][b*8 +: 8];
      if (i == flip) err = 1;
      a = adv(a, size, burst);
    end
    bq.push_back('{id, err ? 2'b10 : 2'b00});
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
    bus.aw_valid = 1;
    wait_hs(0, "aw_handshake");
    bus.aw_valid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.w_data = wd[i]; bus.w_strb = ws[i]; bus.w_last = (i == int'(len)) ^ (i == flip);
      bus.w_valid = 1;
      wait_hs(1, "w_handshake");
    end
    bus.w_valid = 0;
    if (wait_b) drain();
  endtask

  task automatic do_read(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a = addr;
    bit bad;
    for (int i = 0; i <= int'(len); i++) begin
      bad = bad_beat(a, size, burst);
      rq.push_back('{id, bad ? 64'd0 : mem[a >> 3], bad ? 2'b10 : 2'b00, i == int'(len)});
      a = adv(a, size, burst);
    end
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
    bus.ar_valid = 1;
    wait_hs(2, "ar_handshake");
    bus.ar_valid = 0;
    drain();
  endtask

  task automatic fill(input logic [63:0] d, input logic [7:0] s);
    for (int i = 0; i < 256; i++) begin wd[i] = d + 64'(i); ws[i] = s; end
  endtask

  initial begin
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [31:0] base;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    {bus.aw_valid, bus.w_valid, bus.ar_valid, bus.b_ready, bus.r_ready} = '0;
    {bus.aw_lock, bus.aw_cache, bus.aw_prot, bus.aw_qos, bus.aw_region, bus.aw_user} = '0;
    {bus.ar_lock, bus.ar_cache, bus.ar_prot, bus.ar_qos, bus.ar_region, bus.ar_user} = '0;
    {bus.aw_id, bus.aw_addr, bus.aw_len, bus.aw_size, bus.aw_burst} = '0;
    {bus.ar_id, bus.ar_addr, bus.ar_len, bus.ar_size, bus.ar_burst} = '0;
    {bus.w_data, bus.w_strb, bus.w_last, bus.w_user} = '0;
    repeat (3) @(negedge clk);
    chk("rst_aw_ready", 64'(bus.aw_ready), 64'(1'b0));
    chk("rst_ar_ready", 64'(bus.ar_ready), 64'(1'b0));
    chk("rst_valids", 64'({bus.w_ready, bus.b_valid, bus.r_valid, wr_busy, rd_busy}), 64'(5'd0));
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("release_aw_ready_low", 64'(bus.aw_ready), 64'(1'b0));
    @(negedge clk);
    chk("release_aw_ready_high", 64'(bus.aw_ready), 64'(1'b1));
    chk("release_ar_ready_high", 64'(bus.ar_ready), 64'(1'b1));
    @(posedge clk); #1;
    fill(64'd0, 8'hFF);
    for (int i = 0; i < 64; i++) wd[i] = '0;
    do_write(9'h0, 32'h0, 8'd63, 3'd3, 2'b01, -1, 1);
    wd[0] = 64'hDEADBEEF_CAFEF00D; ws[0] = 8'hFF;
    do_write(9'h05, 32'h10, 8'd0, 3'd3, 2'b01, -1, 1);
    do_read(9'h05, 32'h10, 8'd0, 3'd3, 2'b01);
    fill(64'd1, 8'hFF);
    do_write(9'h11, 32'h100, 8'd3, 3'd3, 2'b01, -1, 1);
    do_read(9'h12, 32'h100, 8'd3, 3'd3, 2'b01);
    wd[0] = '1; ws[0] = 8'hFF;
    do_write(9'h20, 32'h40, 8'd0, 3'd3, 2'b01, -1, 1);
    wd[0] = '0; ws[0] = 8'h0F;
    do_write(9'h21, 32'h40, 8'd0, 3'd3, 2'b01, -1, 1);
    chk("model_partial_strb", mem[8], 64'hFFFFFFFF_00000000);
    do_read(9'h22, 32'h40, 8'd0, 3'd3, 2'b01);
    fill(64'h55AA, 8'hFF);
    do_write(9'h30, 32'h2000, 8'd0, 3'd3, 2'b01, -1, 1);
    do_read(9'h31, 32'h2000, 8'd0, 3'd3, 2'b01);
    do_read(9'h32, 32'h0, 8'd0, 3'd3, 2'b01);
    do_write(9'h33, 32'h20, 8'd1, 3'd3, 2'b10, -1, 1);
    do_read(9'h34, 32'h20, 8'd1, 3'd3, 2'b10);
    do_write(9'h35, 32'h60, 8'd0, 3'd4, 2'b01, -1, 1);
    do_read(9'h36, 32'h60, 8'd0, 3'd3, 2'b01);
    fill(64'h77, 8'hFF);
    do_write(9'h37, 32'h30, 8'd1, 3'd3, 2'b01, 0, 1);
    do_read(9'h38, 32'h30, 8'd1, 3'd3, 2'b01);
    fill(64'h900, 8'hFF);
    do_write(9'h39, 32'h48, 8'd3, 3'd3, 2'b00, -1, 1);
    do_read(9'h3A, 32'h48, 8'd2, 3'd3, 2'b00);
    rand_rdy = 0;
    @(posedge clk); #1;
    bus.b_ready = 0; bus.r_ready = 1;
    do_write(9'h3B, 32'h58, 8'd0, 3'd3, 2'b01, -1, 0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_b_valid", 64'(bus.b_valid), 64'(1'b1));
      chk("hold_aw_ready", 64'(bus.aw_ready), 64'(1'b0));
      @(posedge clk); #1;
    end
    bus.b_ready = 1;
    drain();
    rand_rdy = 1;
    for (int k = 0; k < 40; k++) begin
      len = 8'($urandom_range(0, 7));
      size = 3'($urandom_range(0, 3));
      burst = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'($urandom_range(0, 1));
      base = 32'($urandom_range(0, 63 - int'(len))) * 8 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
        do_write(9'($urandom), base, len, size, burst, -1, 1);
      end else do_read(9'($urandom), base, len, size, burst);
    end
    for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    bus.aw_id = 9'h9; bus.aw_addr = 32'h80; bus.aw_len = 8'd7; bus.aw_size = 3'd3;
    bus.aw_burst = 2'b01; bus.aw_valid = 1;
    wait_hs(0, "rst_aw_handshake");
    bus.aw_valid = 0;
    for (int i = 0; i < 2; i++) begin
      mem[16 + i] = wd[i];
      bus.w_data = wd[i]; bus.w_strb = 8'hFF; bus.w_last = 0; bus.w_valid = 1;
      wait_hs(1, "rst_w_handshake");
    end
    bus.w_data = wd[2];
    @(negedge clk);
    rstn = 0;
    @(posedge clk); #1;
    bus.w_valid = 0;
    @(negedge clk);
    chk("midrst_readies", 64'({bus.aw_ready, bus.w_ready, bus.ar_ready}), 64'(3'd0));
    chk("midrst_valids", 64'({bus.b_valid, bus.r_valid, wr_busy, rd_busy}), 64'(4'd0));
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    chk("midrst_aw_ready_low", 64'(bus.aw_ready), 64'(1'b0));
    @(negedge clk);
    chk("midrst_aw_ready_high", 64'(bus.aw_ready), 64'(1'b1));
    chk("midrst_no_b", 64'(bus.b_valid), 64'(1'b0));
    repeat (10) @(posedge clk);
    #1;
    do_read(9'h9, 32'h80, 8'd7, 3'd3, 2'b01);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
